four_bit_full_adder: RTL and testbench
======================================

# four_bit_full_adder

Registered 4-bit ripple-carry adder: adds two 4-bit operands and a carry-in, and presents a 4-bit sum, carry-out and status flags on registered outputs. It is the arithmetic leaf used by the datapath that needs a small unsigned/two's-complement add with qualified (valid-tagged) results. The combinational core is four chained 1-bit full-adder cells. An optional input register stage exists for timing closure.

## Interface

Parameters:
- REG_INPUTS, default 0: 0 means latency 1 (output register only); 1 means latency 2 (input and output registers).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  4  operand A (unsigned or two's complement).
- B  input  4  operand B.
- Cin  input  1  carry-in.
- in_valid  input  1  qualifies A/B/Cin in the current cycle.
- Sum  output  4  registered A+B+Cin, bits [3:0].
- Cout  output  1  registered carry out of bit 3.
- Ovf  output  1  registered signed overflow (carry into bit 3 XOR carry out of bit 3).
- Zero  output  1  registered flag, 1 when Sum == 0 (independent of Cout).
- out_valid  output  1  1 for exactly one cycle per accepted input, aligned with its result.

## Operation

- Core: bit i full adder with s_i = A_i ^ B_i ^ c_i and c_{i+1} = A_i&B_i | (A_i^B_i)&c_i. c_0 = Cin and Cout = c_4.
- {Cout,Sum} equals the 5-bit value A+B+Cin for all 512 input combinations. No saturation; the result wraps modulo 16 in Sum.
- Ovf = c_3 ^ c_4. It is computed for every add and is meaningful when the operands are interpreted as signed.
- Zero = ~|Sum, taken from the same result.
- The block accepts input on every cycle with in_valid=1. There is no backpressure and throughput is one add per clock.
- in_valid=0: the output registers Sum/Cout/Ovf/Zero hold their previous values, and out_valid is 0 in the corresponding output cycle.
- REG_INPUTS=1: A, B, Cin and in_valid are captured in an input register stage. The adder operates on the registered values.

## Timing

- REG_INPUTS=0: if in_valid=1 at edge N, Sum/Cout/Ovf/Zero reflect those inputs after edge N, and out_valid=1 from edge N to edge N+1.
- REG_INPUTS=1: the same behaviour, shifted one edge later (the result appears after edge N+1).
- Back-to-back valid inputs produce back-to-back valid outputs in input order. Nothing is dropped or duplicated.
- Reset, when rst=1 at an edge:
  - Sum=0, Cout=0, Ovf=0, Zero=0 and out_valid=0 after that edge.
  - Input-stage registers are cleared, including the stored in_valid.
- Reset has priority over in_valid in the same cycle. Inputs presented during reset are discarded.
- Reset mid-stream: any add in flight (REG_INPUTS=1) is discarded, and no out_valid pulse is produced for it.
- The first valid result after reset deasserts follows the normal latency. No extra warm-up cycles.
- No combinational path from inputs to outputs.

## Test plan

- Reset: assert rst for 2 cycles with in_valid=1 and A=B=15 -> all outputs 0 and out_valid 0. After release, the first valid add produces its result at nominal latency.
- Directed adds, one per cycle with in_valid=1:
  - A=0, B=0, Cin=0 -> Sum=0, Cout=0, Zero=1, Ovf=0.
  - A=2, B=15, Cin=0 -> Sum=1, Cout=1, Ovf=0.
  - A=4, B=14, Cin=1 -> Sum=3, Cout=1, Ovf=0.
- Overflow:
  - A=8, B=10, Cin=1 -> Sum=3, Cout=1, Ovf=1.
  - A=7, B=1, Cin=0 -> Sum=8, Cout=0, Ovf=1.
  - A=15, B=0, Cin=1 -> Sum=0, Cout=1, Zero=1, Ovf=0.
- Exhaustive sweep: {A,B}=i for i=0..255, Cin=0 then Cin=1, fed back-to-back. Each result must match the reference model {Cout,Sum}=A+B+Cin with correct Ovf/Zero, and out_valid must be high for all 512 cycles, in order.
- Valid gaps: alternate in_valid 1/0 with changing operands -> outputs hold during the gaps, out_valid pulses only for accepted inputs, and the 0-cycle operands never appear.
- Both REG_INPUTS values: rerun the sweep with REG_INPUTS=1 -> identical result sequence delayed by exactly one extra cycle. Assert rst while an add is in flight -> no out_valid for it.

Source files
------------

// File: rtl/four_bit_full_adder.sv
// Registered 4-bit ripple-carry adder with carry, signed-overflow and zero flags.
// Optional input register stage (REG_INPUTS=1) adds one cycle of latency.
module four_bit_full_adder #(
    parameter int REG_INPUTS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    input  logic       in_valid,
    output logic [3:0] Sum,
    output logic       Cout,
    output logic       Ovf,
    output logic       Zero,
    output logic       out_valid
);

    logic [3:0] a_core;
    logic [3:0] b_core;
    logic       cin_core;
    logic       valid_core;

    generate
        if (REG_INPUTS != 0) begin : g_in_reg
            logic [3:0] a_reg;
            logic [3:0] b_reg;
            logic       cin_reg;
            logic       valid_reg;

            // Clearing valid_reg on reset is what drops an add that is in flight.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_reg     <= '0;
                    b_reg     <= '0;
                    cin_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                end else begin
                    a_reg     <= A;
                    b_reg     <= B;
                    cin_reg   <= Cin;
                    valid_reg <= in_valid;
                end
            end

            assign a_core     = a_reg;
            assign b_core     = b_reg;
            assign cin_core   = cin_reg;
            assign valid_core = valid_reg;
        end else begin : g_in_comb
            assign a_core     = A;
            assign b_core     = B;
            assign cin_core   = Cin;
            assign valid_core = in_valid;
        end
    endgenerate

    logic [4:0] carry;
    logic [3:0] sum_next;

    assign carry[0] = cin_core;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum_next[gi]  = a_core[gi] ^ b_core[gi] ^ carry[gi];
            assign carry[gi + 1] = (a_core[gi] & b_core[gi])
                                 | ((a_core[gi] ^ b_core[gi]) & carry[gi]);
        end
    endgenerate

    logic [3:0] sum_reg;
    logic       cout_reg;
    logic       ovf_reg;
    logic       zero_reg;
    logic       valid_reg_out;

    // Result registers only load on a qualified add; otherwise they hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
            valid_reg_out <= 1'b0;
        end else begin
            valid_reg_out <= valid_core;
            if (valid_core) begin
                sum_reg  <= sum_next;
                cout_reg <= carry[4];
                ovf_reg  <= carry[3] ^ carry[4];
                zero_reg <= ~|sum_next;
            end
        end
    end

    assign Sum       = sum_reg;
    assign Cout      = cout_reg;
    assign Ovf       = ovf_reg;
    assign Zero      = zero_reg;
    assign out_valid = valid_reg_out;

endmodule

// File: tb/tb_four_bit_full_adder.sv
// Self-checking bench: runs both REG_INPUTS variants side by side on shared stimulus,
// with a hand-computed vector table plus an arithmetic reference model every cycle.
module tb_four_bit_full_adder;

    typedef struct packed {
        logic       v;
        logic [3:0] s;
        logic       c;
        logic       o;
        logic       z;
    } res_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       in_valid;

    logic [3:0] sum0, sum1;
    logic       cout0, cout1, ovf0, ovf1, zero0, zero1, ov0, ov1;

    four_bit_full_adder #(.REG_INPUTS(0)) dut0 (
        .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .in_valid(in_valid),
        .Sum(sum0), .Cout(cout0), .Ovf(ovf0), .Zero(zero0), .out_valid(ov0)
    );

    four_bit_full_adder #(.REG_INPUTS(1)) dut1 (
        .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .in_valid(in_valid),
        .Sum(sum1), .Cout(cout1), .Ovf(ovf1), .Zero(zero1), .out_valid(ov1)
    );

    always #5 clk = ~clk;

    res_t r0, r1;
    assign r0 = '{v: ov0, s: sum0, c: cout0, o: ovf0, z: zero0};
    assign r1 = '{v: ov1, s: sum1, c: cout1, o: ovf1, z: zero1};

    int checks = 0;
    int errors = 0;

    // Reference state: expected outputs of each DUT and the modelled input stage.
    res_t       m0, m1;
    logic       st_v;
    logic [3:0] st_a, st_b;
    logic       st_c;

    function automatic res_t ref_add(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [4:0] t;
        res_t r;
        t   = {1'b0, x} + {1'b0, y} + {4'b0, ci};
        r.v = 1'b1;
        r.s = t[3:0];
        r.c = t[4];
        r.o = (x[3] == y[3]) && (t[3] != x[3]);
        r.z = (t[3:0] == 4'd0);
        return r;
    endfunction

    task automatic chk(input string name, input res_t act, input res_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got v=%b s=%0d c=%b o=%b z=%b, expected v=%b s=%0d c=%b o=%b z=%b",
                     name, act.v, act.s, act.c, act.o, act.z, exp.v, exp.s, exp.c, exp.o, exp.z);
        end
    endtask

    // One clock: update the reference on the edge, then compare both DUTs.
    task automatic tick();
        logic       c_rst, c_v, c_c;
        logic [3:0] c_a, c_b;
        res_t       hold;
        c_rst = rst; c_v = in_valid; c_a = a; c_b = b; c_c = cin;
        @(posedge clk);
        if (c_rst) begin
            m0 = '0; m1 = '0;
            st_v = 1'b0; st_a = '0; st_b = '0; st_c = 1'b0;
        end else begin
            if (c_v) m0 = ref_add(c_a, c_b, c_c);
            else begin hold = m0; hold.v = 1'b0; m0 = hold; end
            if (st_v) m1 = ref_add(st_a, st_b, st_c);
            else begin hold = m1; hold.v = 1'b0; m1 = hold; end
            st_v = c_v; st_a = c_a; st_b = c_b; st_c = c_c;
        end
        #1;
        chk("model_dut0", r0, m0);
        chk("model_dut1", r1, m1);
        if (ov0) $display("txn dut0 t=%0t sum=%0d cout=%b ovf=%b zero=%b", $time, sum0, cout0, ovf0, zero0);
    endtask

    vec_t vecs[8];

    initial begin
        res_t  exp;
        m0 = '0; m1 = '0;
        st_v = 1'b0; st_a = '0; st_b = '0; st_c = 1'b0;

        vecs[0] = '{4'd0,  4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{4'd2,  4'd15, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'd4,  4'd14, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{4'd8,  4'd10, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{4'd7,  4'd1,  1'b0, 4'd8, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{4'd15, 4'd0,  1'b1, 4'd0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{4'd5,  4'd3,  1'b0, 4'd8, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{4'd9,  4'd9,  1'b0, 4'd2, 1'b1, 1'b1, 1'b0};

        // Reset for two cycles with a valid all-ones add presented.
        rst = 1'b1; in_valid = 1'b1; a = 4'd15; b = 4'd15; cin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("reset_dut0", r0, res_t'(0));
            chk("reset_dut1", r1, res_t'(0));
        end

        // First add after reset at nominal latency.
        rst = 1'b0; in_valid = 1'b1; a = 4'd6; b = 4'd7; cin = 1'b0;
        tick();
        chk("first_dut0", r0, '{1'b1, 4'd13, 1'b0, 1'b1, 1'b0});
        in_valid = 1'b0; a = 4'd1; b = 4'd1;
        tick();
        chk("first_dut1", r1, '{1'b1, 4'd13, 1'b0, 1'b1, 1'b0});

        // Table vectors, each followed by a gap cycle with different operands.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
            exp = '{1'b1, vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero};
            tick();
            chk($sformatf("vec%0d_dut0", i), r0, exp);
            in_valid = 1'b0; a = ~vecs[i].a; b = vecs[i].a; cin = ~vecs[i].cin;
            tick();
            chk($sformatf("vec%0d_dut1", i), r1, exp);
            exp.v = 1'b0;
            chk($sformatf("vec%0d_hold_dut0", i), r0, exp);
        end

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] idx;
            idx = 9'(i);
            in_valid = 1'b1; cin = idx[8]; a = idx[7:4]; b = idx[3:0];
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();

        // Reset with an add in flight in the input stage.
        in_valid = 1'b1; a = 4'd3; b = 4'd4; cin = 1'b0;
        tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("inflight_dut1", r1, res_t'(0));
        tick();
        chk("inflight_dut1_late", r1, res_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
